instr_encoder: RTL and testbench

Packs MIPS instruction fields into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. Fields use the same layout the pipeline decoder splits apart. The block is used by the test/boot loader to assemble programs in-system.
A DEPTH-entry FIFO sits between the field interface and the memory write port and absorbs imem backpressure.

---
 rtl/instr_encoder_if.sv | 44 ++++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Purpose  : Field-set and imem write-port signals for instr_encoder.
// Revision : 1.0
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       immediate;
    logic [25:0]       target;
    logic [4:0]        cs;
    logic [2:0]        sel;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   wr_count;
    logic              busy;

    modport slave (
        input  in_valid, fmt, op, rs, rt, rd, shamt, func, immediate, target,
               cs, sel, addr_load, addr_in, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, wr_count, busy
    );

    modport master (
        output in_valid, fmt, op, rs, rt, rd, shamt, func, immediate, target,
               cs, sel, addr_load, addr_in, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, wr_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs MIPS fields into words, buffers them, streams them to imem.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    instr_encoder_if.slave    bus
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] FMT_R    = 2'd0;
    localparam logic [1:0] FMT_I    = 2'd1;
    localparam logic [1:0] FMT_J    = 2'd2;

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;

    logic        busy;
    logic        in_ready;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    always_comb begin
        enc_word = {bus.op, bus.rs, bus.rt, bus.cs, 8'b0, bus.sel};
        case (bus.fmt)
            FMT_R:   enc_word = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
            FMT_I:   enc_word = {bus.op, bus.rs, bus.rt, bus.immediate};
            FMT_J:   enc_word = {bus.op, bus.target};
            default: enc_word = {bus.op, bus.rs, bus.rt, bus.cs, 8'b0, bus.sel};
        endcase
    end

    // Readiness looks only at occupancy, so a full FIFO refuses even on a pop cycle.
    assign busy     = (count_q != '0);
    assign in_ready = !rst && !bus.addr_load && (count_q != FULL_CNT);
    assign push     = bus.in_valid && in_ready;
    assign pop      = busy && bus.imem_ready && !bus.addr_load;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        if (bus.addr_load) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            addr_d     = bus.addr_in;
            wr_count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                addr_d     = addr_q + ADDR_W'(1);
                wr_count_d = wr_count_q + (ADDR_W+1)'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            wr_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.imem_we    = busy;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = busy ? mem_q[rd_ptr_q] : 32'h0;
    assign bus.wr_count   = wr_count_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Vector table, directed corner sequences and random traffic.
// Revision : 1.0
// ============================================================================
module tb_instr_encoder;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] target;
        logic [4:0]  cs;
        logic [2:0]  sel;
    } fields_t;

    typedef struct {
        fields_t     f;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: the pending words in order, the next write address
    // and the completed-write count.
    logic [31:0] mq[$];
    int          m_addr  = 0;
    int          m_wc    = 0;
    bit          m_valid = 0;
    fields_t     cur;

    function automatic fields_t mk(input int fmt, input int op, input int rs, input int rt,
                                   input int rd, input int shamt, input int func, input int imm,
                                   input int target, input int cs, input int sel);
        fields_t f;
        f.fmt = 2'(fmt);   f.op = 6'(op);       f.rs = 5'(rs);   f.rt = 5'(rt);
        f.rd = 5'(rd);     f.shamt = 5'(shamt); f.func = 6'(func);
        f.imm = 16'(imm);  f.target = 26'(target);
        f.cs = 5'(cs);     f.sel = 3'(sel);
        return f;
    endfunction

    function automatic fields_t rand_fields();
        return mk($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 63), $urandom_range(0, 65535),
                  $urandom_range(0, 32'h3FFFFFF), $urandom_range(0, 31), $urandom_range(0, 7));
    endfunction

    // Field packing by positional weight (each field shifts the previous ones up).
    function automatic logic [31:0] ref_encode(input fields_t f);
        longint unsigned v;
        v = 64'(f.op);
        case (f.fmt)
            2'd0: begin
                v = v * 64'd32 + 64'(f.rs);
                v = v * 64'd32 + 64'(f.rt);
                v = v * 64'd32 + 64'(f.rd);
                v = v * 64'd32 + 64'(f.shamt);
                v = v * 64'd64 + 64'(f.func);
            end
            2'd1: begin
                v = v * 64'd32 + 64'(f.rs);
                v = v * 64'd32 + 64'(f.rt);
                v = v * 64'd65536 + 64'(f.imm);
            end
            2'd2: v = v * 64'd67108864 + 64'(f.target);
            default: begin
                v = v * 64'd32 + 64'(f.rs);
                v = v * 64'd32 + 64'(f.rt);
                v = v * 64'd2048 * 64'd32 + 64'(f.cs) * 64'd2048 + 64'(f.sel);
            end
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input fields_t f, input logic valid);
        cur           = f;
        bus.fmt       = f.fmt;   bus.op    = f.op;    bus.rs   = f.rs;   bus.rt = f.rt;
        bus.rd        = f.rd;    bus.shamt = f.shamt; bus.func = f.func;
        bus.immediate = f.imm;   bus.target = f.target;
        bus.cs        = f.cs;    bus.sel   = f.sel;
        bus.in_valid  = valid;
    endtask

    task automatic check_model();
        chk("in_ready",   64'(bus.in_ready),   64'(!rst && !bus.addr_load && mq.size() < DEPTH));
        chk("imem_we",    64'(bus.imem_we),    64'(mq.size() != 0));
        chk("busy",       64'(bus.busy),       64'(mq.size() != 0));
        chk("imem_addr",  64'(bus.imem_addr),  64'(m_addr));
        chk("imem_wdata", 64'(bus.imem_wdata), (mq.size() != 0) ? 64'(mq[0]) : 64'h0);
        chk("wr_count",   64'(bus.wr_count),   64'(m_wc));
    endtask

    // One clock: check outputs against the model, then advance both together.
    task automatic cycle();
        bit do_rst, do_load, do_pop, do_push;
        logic [31:0] w;
        #1;
        if (m_valid) check_model();
        do_rst  = rst;
        do_load = bus.addr_load;
        do_pop  = mq.size() != 0 && bus.imem_ready;
        do_push = bus.in_valid && mq.size() < DEPTH;
        w       = ref_encode(cur);
        @(posedge clk);
        if (do_rst) begin
            mq.delete(); m_addr = 0; m_wc = 0; m_valid = 1;
        end else if (do_load) begin
            mq.delete(); m_addr = int'(bus.addr_in); m_wc = 0;
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                m_wc   = (m_wc + 1) % (1 << (ADDR_W + 1));
            end
            if (do_push) mq.push_back(w);
        end
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{mk(0, 0, 1, 2, 3, 0, 6'h20, 0, 0, 0, 0), 32'h00221820};
        tbl[1] = '{mk(1, 6'h08, 1, 2, 0, 0, 0, 16'h0005, 0, 0, 0), 32'h20220005};
        tbl[2] = '{mk(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h10, 0, 0), 32'h08000010};
        tbl[3] = '{mk(3, 6'h10, 0, 8, 0, 0, 0, 0, 0, 12, 0), 32'h40086000};
        tbl[4] = '{mk(0, 0, 4, 5, 6, 2, 0, 16'hFFFF, 26'h3FFFFFF, 31, 7), 32'h00853080};
        tbl[5] = '{mk(1, 6'h23, 29, 31, 7, 9, 6'h3F, 16'h8004, 0, 3, 1), 32'h8FBF8004};
        tbl[6] = '{mk(2, 6'h03, 31, 31, 31, 31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 31, 7), 32'h0FFFFFFF};
        tbl[7] = '{mk(3, 6'h10, 4, 9, 21, 17, 6'h3F, 16'hAAAA, 0, 13, 7), 32'h40896807};

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        bus.addr_load = 1'b0; bus.addr_in = '0; bus.imem_ready = 1'b1;
        rst = 1'b1;
        repeat (3) cycle();
        chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset_we",       64'(bus.imem_we),  64'd0);
        chk("reset_wdata",    64'(bus.imem_wdata), 64'd0);
        rst = 1'b0;
        #1 chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        // Table vectors, one word at a time, each written at the next address.
        foreach (tbl[i]) begin
            drive(tbl[i].f, 1'b1);
            cycle();
            drive(tbl[i].f, 1'b0);
            chk("tbl_we",    64'(bus.imem_we),    64'd1);
            chk("tbl_wdata", 64'(bus.imem_wdata), 64'(tbl[i].exp));
            chk("tbl_addr",  64'(bus.imem_addr),  64'(i));
            cycle();
            chk("tbl_wr_count", 64'(bus.wr_count), 64'(i + 1));
        end

        // Back-to-back pushes stream on consecutive cycles.
        for (int i = 1; i <= 3; i++) begin
            drive(tbl[i].f, 1'b1);
            cycle();
        end
        drive(cur, 1'b0);
        repeat (4) cycle();

        // Backpressure: fill the FIFO with imem stalled, then drain.
        rst = 1'b1; cycle(); rst = 1'b0;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(rand_fields(), 1'b1);
            cycle();
        end
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        begin
            logic [31:0] held_w;
            held_w = bus.imem_wdata;
            repeat (3) cycle();
            chk("stall_addr",  64'(bus.imem_addr),  64'd0);
            chk("stall_wdata", 64'(bus.imem_wdata), 64'(held_w));
        end
        bus.imem_ready = 1'b1;
        cycle();
        drive(cur, 1'b0);
        chk("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) cycle();
        chk("drain_addr", 64'(bus.imem_addr), 64'd4);

        // Address wrap at the top of imem.
        bus.addr_load = 1'b1; bus.addr_in = 10'h3FF;
        cycle();
        bus.addr_load = 1'b0;
        chk("load_addr", 64'(bus.imem_addr), 64'h3FF);
        drive(tbl[0].f, 1'b1);
        cycle();
        drive(tbl[1].f, 1'b1);
        cycle();
        drive(cur, 1'b0);
        chk("wrap_addr", 64'(bus.imem_addr), 64'h000);
        cycle();
        chk("wrap_wr_count", 64'(bus.wr_count), 64'd2);

        // addr_load flushes pending words and refuses a same-cycle push.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(rand_fields(), 1'b1);
            cycle();
        end
        bus.addr_load = 1'b1; bus.addr_in = 10'h100;
        cycle();
        bus.addr_load = 1'b0;
        drive(cur, 1'b0);
        chk("flush_busy", 64'(bus.busy),    64'd0);
        chk("flush_we",   64'(bus.imem_we), 64'd0);
        bus.imem_ready = 1'b1;
        drive(tbl[3].f, 1'b1);
        cycle();
        drive(cur, 1'b0);
        chk("flush_addr", 64'(bus.imem_addr), 64'h100);
        cycle();
        chk("flush_wr_count", 64'(bus.wr_count), 64'd1);

        // Reset mid-stream.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(rand_fields(), 1'b1);
            cycle();
        end
        drive(cur, 1'b0);
        rst = 1'b1;
        cycle();
        chk("midrst_we",       64'(bus.imem_we),  64'd0);
        chk("midrst_addr",     64'(bus.imem_addr), 64'd0);
        chk("midrst_wr_count", 64'(bus.wr_count), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1 chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            drive(rand_fields(), 1'($urandom_range(0, 3) != 0));
            bus.imem_ready = 1'($urandom_range(0, 2) != 0);
            bus.addr_load  = 1'($urandom_range(0, 40) == 0);
            bus.addr_in    = ADDR_W'($urandom);
            rst            = 1'($urandom_range(0, 90) == 0);
            cycle();
        end
        rst = 1'b0; bus.addr_load = 1'b0; bus.imem_ready = 1'b1;
        drive(cur, 1'b0);
        repeat (DEPTH + 2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
